data_mem_lsu: RTL
=================

Name: data_mem_lsu

Overview:
- Parametrised successor to the word-only data memory. Adds byte/halfword/word loads and stores with sign/zero extension and per-byte write enables.
- Adds a registered synchronous read with a valid/ready handshake on both request and response, plus misalignment and out-of-range fault reporting.
- Sits between the core's MEM stage and the word-addressed RAM array.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; power of two, at least 4
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH*4
IDX_W, $clog2(DEPTH), word index width (derived, not overridden)

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_size  in  2  00 byte, 01 halfword, 10 word; 11 is illegal
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0])
resp_valid  out  1  response held in the output register
resp_ready  in  1  consumer accepts the response
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_err  out  2  00 ok, 01 misaligned, 10 out-of-range, 11 illegal size

Behaviour:
- Interface facts: one clock named clk; reset named rst is synchronous and active-high.
- Reset: resp_valid=0, resp_rdata=0, resp_err=00. The memory array is not reset; its contents are undefined until written.
- req_ready = !resp_valid || resp_ready, computed combinationally from registered state.
- A request is accepted when req_valid && req_ready at a posedge.
- Latency:
  - The response is registered and valid in the cycle after acceptance.
  - Back-to-back requests sustain one per cycle while resp_ready=1.
- Response register:
  - Loads on accept.
  - Cleared (resp_valid←0) when resp_valid && resp_ready && !accept.
  - Holds all fields while resp_valid && !resp_ready.
- Address decode:
  - off = req_addr - BASE_ADDR.
  - Word index = off[IDX_W+1:2]; byte lane = off[1:0].
- Fault priority: illegal size (11) > out-of-range (req_addr < BASE_ADDR or off >= DEPTH*4) > misaligned (half with lane[0]=1, or word with lane≠00).
- A faulting request:
  - Writes nothing to the array.
  - Still produces a response with the error code and resp_rdata=0.
- Stores:
  - Byte-enable mask: byte = 0001<<lane; half = 0011<<lane; word = 1111.
  - Write data is replicated across lanes (byte ×4, half ×2).
  - Only enabled bytes of mem[idx] update, at the accept edge.
  - Response: err=00, rdata=0.
- Loads:
  - The full word mem[idx] is registered at accept.
  - The lane is selected and extended per size/unsigned, then registered as resp_rdata.
  - The unsigned flag is ignored for word loads.
- Same-address store followed by load on the next cycle: the load returns the new data. The write completes at the first edge, before the read edge.
- Simultaneous accept and response consume in one cycle: the new response replaces the old one and resp_valid stays 1.
- Reset asserted mid-operation:
  - A pending response is dropped (resp_valid←0).
  - A store presented in the reset cycle is not written.
  - req_ready is 1 in the cycle after reset deasserts.
- Unused off[31:IDX_W+2] bits participate only in the range check.

Decomposition:
- Package dmem_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - error codes (ERR_OK, ERR_MISALIGN, ERR_RANGE, ERR_SIZE)
  - a function for byte-enable generation
- One combinational sub-module, dmem_lane_align, covers:
  - store byte-enable and data replication
  - load lane extract and sign/zero extension
- Top level keeps the array, handshake and fault logic.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 with resp_ready=1 → store response err=00 rdata=0; load response next cycle rdata=0xDEADBEEF, err=00.
- After the above, SB 0x7F @0x11, then LB/LBU @0x11 and LW @0x10 → 0x0000007F / 0x0000007F / 0xDEAD7FEF.
- SH 0x8001 @0x12, then LH @0x12 → 0xFFFF8001; LHU @0x12 → 0x00008001.
- LW @0x13, LH @0x11, size=11 @0x10 → err 01, 01, 11 respectively, rdata=0; a following LW @0x10 proves memory unchanged.
- SW @DEPTH*4 (0x1000) → err=10, no write; then LW @0x0 gets its previously written value.
- Hold resp_ready=0 for 3 cycles with a load pending → req_ready=0, resp fields stable. Release → response consumed and the next request accepted in the same cycle. Assert rst with resp_valid=1 → resp_valid=0 the next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte/halfword/word data-memory load/store unit.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  // Per-byte write enable for a store of the given size starting at byte lane 'lane'.
  // Misaligned combinations produce a mask too, but the top level faults them before use.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = 4'b0011 << lane;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and data replication on the way in,
// lane extract with sign/zero extension on the way out.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  // Store side: enables from the shared helper, data copied into every lane it may land in.
  always_comb begin
    st_be = byte_en(st_size, st_lane);
    case (st_size)
      SZ_BYTE: st_wdata_rep = {4{st_wdata[7:0]}};
      SZ_HALF: st_wdata_rep = {2{st_wdata[15:0]}};
      default: st_wdata_rep = st_wdata;
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load side: pick the addressed byte/halfword and extend; word loads ignore the unsigned flag.
  always_comb begin
    ld_byte = ld_word[8*ld_lane +: 8];
    ld_half = ld_word[16*ld_lane[1] +: 16];
    case (ld_size)
      SZ_BYTE: ld_data = ld_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = ld_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Data memory load/store unit: word-addressed array with byte/half/word access,
// valid/ready request and response handshakes, and fault reporting.
module data_mem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);

  // One past the last byte offset; 33 bits so DEPTH*4 never wraps.
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

  logic              accept;
  logic [31:0]       off;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [1:0]        fault;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata_rep;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word_q;

  logic [1:0]        resp_err_q;
  logic              ld_ok_q;
  logic [1:0]        ld_size_q;
  logic [1:0]        ld_lane_q;
  logic              ld_unsigned_q;
  logic [31:0]       ld_data;

  // Handshake: the output register can take a new response if empty or being drained.
  always_comb begin
    req_ready = !resp_valid || resp_ready;
    accept    = req_valid && req_ready;
  end

  // Address decode and fault classification, highest priority first.
  always_comb begin
    off  = req_addr - BASE_ADDR;
    idx  = off[IDX_W+1:2];
    lane = off[1:0];
    if (req_size == SZ_ILL)
      fault = ERR_SIZE;
    else if (req_addr < BASE_ADDR || {1'b0, off} >= LIMIT)
      fault = ERR_RANGE;
    else if ((req_size == SZ_HALF && lane[0]) || (req_size == SZ_WORD && lane != 2'b00))
      fault = ERR_MISALIGN;
    else
      fault = ERR_OK;
  end

  dmem_lane_align u_align (
    .st_size      (req_size),
    .st_lane      (lane),
    .st_wdata     (req_wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_size      (ld_size_q),
    .ld_lane      (ld_lane_q),
    .ld_unsigned  (ld_unsigned_q),
    .ld_word      (rd_word_q),
    .ld_data      (ld_data)
  );

  // Array: clean stores write enabled bytes; every accept captures the addressed word.
  always_ff @(posedge clk) begin
    if (accept && !rst && req_write && fault == ERR_OK) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[idx][8*b +: 8] <= st_wdata_rep[8*b +: 8];
      end
    end
    if (accept) rd_word_q <= mem[idx];
  end

  // Response register: load on accept, drop when consumed, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid    <= 1'b0;
      resp_err_q    <= ERR_OK;
      ld_ok_q       <= 1'b0;
      ld_size_q     <= SZ_WORD;
      ld_lane_q     <= 2'b00;
      ld_unsigned_q <= 1'b0;
    end else if (accept) begin
      resp_valid    <= 1'b1;
      resp_err_q    <= fault;
      ld_ok_q       <= !req_write && fault == ERR_OK;
      ld_size_q     <= req_size;
      ld_lane_q     <= lane;
      ld_unsigned_q <= req_unsigned;
    end else if (resp_valid && resp_ready) begin
      resp_valid    <= 1'b0;
    end
  end

  // Stores and faults report zero data; only clean loads expose the extended word.
  always_comb begin
    resp_rdata = ld_ok_q ? ld_data : 32'h0;
    resp_err   = resp_err_q;
  end

endmodule
